sw_debounce: RTL

- Upstream input-conditioning stage for the switch-display path.
- Takes the raw, active-low 4-bit DIP switch bus and synchronises it into clk.
- Debounces the bus as a vector and presents a clean active-high value, the value it replaced, a one-cycle change strobe and a held 0..9 digit.
- The display stage consumes these outputs directly. It must not invert the switches itself or compare values itself.

---
 rtl/sw_debounce.sv | 48 ++++
 1 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: syncs/debounces active-low switch bus -> sw_val, sw_prev, sw_chg strobe, held digit, digit_ok
module sw_debounce #(
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] switch,
  output logic [3:0] sw_val,
  output logic [3:0] sw_prev,
  output logic       sw_chg,
  output logic [3:0] digit,
  output logic       digit_ok
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(STABLE_CNT - 1);
  logic [3:0] sync1, sync2, cand, s;
  logic [CNT_W-1:0] cnt;
  logic sat, acc;
  always_comb begin
    s = ~sync2;
    sat = cnt == MAX;
    acc = (s == cand) && sat && (cand != sw_val);
    digit_ok = sw_val <= 4'd9;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      cand <= '0;
      cnt <= '0;
      sw_val <= '0;
      sw_prev <= '0;
      sw_chg <= 1'b0;
      digit <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
      cand <= s;
      cnt <= (s != cand) ? '0 : sat ? cnt : cnt + 1'b1;
      sw_chg <= acc;
      if (acc) begin
        sw_prev <= sw_val;
        sw_val <= cand;
        if (cand <= 4'd9) digit <= cand;
      end
    end
  end
endmodule
